// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with exact occupancy count, programmable
// almost-full/almost-empty levels, FWFT or registered read, sticky errors
// and synchronous flush.
// Ports: CLK, RST (async, active-low), FLUSH, W_INC/WR_DATA (write side),
// R_INC/RD_DATA/RD_VALID (read side), FULL/EMPTY/ALMOST_FULL/ALMOST_EMPTY,
// COUNT (0..DEPTH), OVERFLOW/UNDERFLOW (sticky until FLUSH or RST).
`timescale 1ns/1ps
module sync_fifo_flex #(
    parameter int WIDTH    = 8,
    parameter int ADDRESS  = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FLUSH,
    input  logic               W_INC,
    input  logic [WIDTH-1:0]   WR_DATA,
    input  logic               R_INC,
    output logic [WIDTH-1:0]   RD_DATA,
    output logic               RD_VALID,
    output logic               FULL,
    output logic               EMPTY,
    output logic               ALMOST_FULL,
    output logic               ALMOST_EMPTY,
    output logic [ADDRESS:0]   COUNT,
    output logic               OVERFLOW,
    output logic               UNDERFLOW
);
    localparam int DEPTH = 1 << ADDRESS;
    localparam logic [ADDRESS:0] DEPTH_C = (ADDRESS+1)'(DEPTH);
    localparam logic [ADDRESS:0] AF_C    = (ADDRESS+1)'(AF_LEVEL);
    localparam logic [ADDRESS:0] AE_C    = (ADDRESS+1)'(AE_LEVEL);
    localparam logic [ADDRESS:0] ONE_C   = {{ADDRESS{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [ADDRESS:0] wptr_q, wptr_d;
    logic [ADDRESS:0] rptr_q, rptr_d;
    logic [ADDRESS:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_ok, rd_ok;

    // Acceptance uses the pre-edge flags, so a full FIFO rejects a write
    // even when a read in the same cycle frees a slot.
    assign wr_ok = W_INC & ~full_q & ~FLUSH;
    assign rd_ok = R_INC & ~empty_q & ~FLUSH;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (FLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + ONE_C;
            if (rd_ok) rptr_d = rptr_q + ONE_C;
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (W_INC & full_q);
            udf_d = udf_q | (R_INC & empty_q);
        end
        // Flags come from the next count so they are valid right after the edge.
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) mem_q[wptr_q[ADDRESS-1:0]] <= WR_DATA;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so the
            // output never exposes stale or uninitialised storage.
            assign RD_DATA  = empty_q ? '0 : mem_q[rptr_q[ADDRESS-1:0]];
            assign RD_VALID = ~empty_q;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) rd_data_q <= mem_q[rptr_q[ADDRESS-1:0]];
                end
            end
            assign RD_DATA  = rd_data_q;
            assign RD_VALID = rd_valid_q;
        end
    endgenerate

    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives a registered-read and an FWFT instance with the
// same stimulus and checks both against a queue model of the FIFO.
`timescale 1ns/1ps
module tb_sync_fifo_flex;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       FLUSH = 1'b0;
    logic       W_INC = 1'b0;
    logic [7:0] WR_DATA = '0;
    logic       R_INC = 1'b0;

    logic [7:0] rd0, rd1;
    logic       rv0, rv1;
    logic       full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1;
    logic [3:0] cnt0, cnt1;
    logic       ovf0, ovf1, udf0, udf1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       mon_en = 1'b0;

    always #5 CLK = ~CLK;

    sync_fifo_flex #(.WIDTH(8), .ADDRESS(3), .AF_LEVEL(6),
                     .AE_LEVEL(2), .FWFT(0)) d0 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .W_INC(W_INC),
        .WR_DATA(WR_DATA), .R_INC(R_INC), .RD_DATA(rd0), .RD_VALID(rv0),
        .FULL(full0), .EMPTY(empty0), .ALMOST_FULL(af0),
        .ALMOST_EMPTY(ae0), .COUNT(cnt0), .OVERFLOW(ovf0),
        .UNDERFLOW(udf0));

    sync_fifo_flex #(.WIDTH(8), .ADDRESS(3), .AF_LEVEL(6),
                     .AE_LEVEL(2), .FWFT(1)) d1 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .W_INC(W_INC),
        .WR_DATA(WR_DATA), .R_INC(R_INC), .RD_DATA(rd1), .RD_VALID(rv1),
        .FULL(full1), .EMPTY(empty1), .ALMOST_FULL(af1),
        .ALMOST_EMPTY(ae1), .COUNT(cnt1), .OVERFLOW(ovf1),
        .UNDERFLOW(udf1));

    // {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW}
    function automatic logic [5:0] exp_flags();
        int n = mq.size();
        return {n == 8, n == 0, n >= 6, n <= 2, m_ovf, m_udf};
    endfunction

    // Registered-read scoreboard plus FWFT head/flag tracking.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (rv0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd0_unexpected got=%02h want=none", rd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rd0 !== e) begin
                        miscompares++;
                        $display("FAIL rd0_data got=%02h want=%02h", rd0, e);
                    end
                end
            end
            vectors++;
            if (rv1 !== (mq.size() != 0)) begin
                miscompares++;
                $display("FAIL rv1 got=%b want=%b", rv1, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                vectors++;
                if (rd1 !== mq[0]) begin
                    miscompares++;
                    $display("FAIL rd1_head got=%02h want=%02h", rd1, mq[0]);
                end
            end
            vectors++;
            if ({full1, empty1, af1, ae1, ovf1, udf1} !== exp_flags() ||
                cnt1 !== 4'(mq.size())) begin
                miscompares++;
                $display("FAIL d1_status got=%b/%0d want=%b/%0d",
                         {full1, empty1, af1, ae1, ovf1, udf1}, cnt1,
                         exp_flags(), mq.size());
            end
        end
    end

    // One clock of stimulus; model updated after the edge it describes.
    task automatic cycle(input logic w, input logic [7:0] d,
                         input logic r, input logic f);
        logic wok, rok, full_m, empty_m;
        W_INC = w; WR_DATA = d; R_INC = r; FLUSH = f;
        full_m  = (mq.size() == 8);
        empty_m = (mq.size() == 0);
        wok = w && !f && !full_m;
        rok = r && !f && !empty_m;
        @(posedge CLK);
        #1;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && full_m) m_ovf = 1'b1;
            if (r && empty_m) m_udf = 1'b1;
            if (rok) exp_q.push_back(mq.pop_front());
            if (wok) mq.push_back(d);
        end
        W_INC = 1'b0; R_INC = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #12;
        vectors++;
        if ({rd0, rv0, full0, empty0, af0, ae0, cnt0, ovf0, udf0} !==
            {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_d0 got=%02h %b %b%b%b%b %0d %b%b", rd0, rv0,
                     full0, empty0, af0, ae0, cnt0, ovf0, udf0);
        end
        vectors++;
        if ({rd1, rv1, empty1, cnt1} !== {8'h00, 1'b0, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_d1 got=%02h %b %b %0d want=00 0 1 0",
                     rd1, rv1, empty1, cnt1);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
            vectors++;
            if (cnt0 !== 4'(i) ||
                {full0, empty0, af0, ae0, ovf0, udf0} !== exp_flags()) begin
                miscompares++;
                $display("FAIL fill%0d got=%0d/%b want=%0d/%b", i, cnt0,
                         {full0, empty0, af0, ae0, ovf0, udf0}, i,
                         exp_flags());
            end
        end
    endtask

    task automatic test_drain();
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (cnt0 !== 4'(i) ||
                {full0, empty0, af0, ae0, ovf0, udf0} !== exp_flags()) begin
                miscompares++;
                $display("FAIL drain%0d got=%0d/%b want=%0d/%b", i, cnt0,
                         {full0, empty0, af0, ae0, ovf0, udf0}, i,
                         exp_flags());
            end
        end
        // Walk the pointers past the wrap point.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (empty0 !== 1'b1 || cnt0 !== 4'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_end got=e%b c%0d q%0d want=e1 c0 q0",
                     empty0, cnt0, exp_q.size());
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        vectors++;
        if (cnt0 !== 4'd7 || ovf0 !== 1'b1 || full0 !== 1'b0) begin
            miscompares++;
            $display("FAIL full_rw got=c%0d o%b f%b want=c7 o1 f0",
                     cnt0, ovf0, full0);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (ovf0 !== 1'b1 || empty0 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky got=o%b e%b want=o1 e1", ovf0, empty0);
        end
    endtask

    task automatic test_fwft();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h5C, 1'b0, 1'b0);
        vectors++;
        if (rd1 !== 8'h5C || rv1 !== 1'b1) begin
            miscompares++;
            $display("FAIL fwft_show got=%02h v%b want=5c v1", rd1, rv1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (empty1 !== 1'b1 || rv1 !== 1'b0 || udf1 !== 1'b0) begin
            miscompares++;
            $display("FAIL fwft_pop got=e%b v%b u%b want=e1 v0 u0",
                     empty1, rv1, udf1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (udf1 !== 1'b1 || udf0 !== 1'b1 || cnt1 !== 4'd0) begin
            miscompares++;
            $display("FAIL underflow got=u%b/%b c%0d want=u1/1 c0",
                     udf1, udf0, cnt1);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        vectors++;
        if (cnt0 !== 4'd4) begin
            miscompares++;
            $display("FAIL pre_flush got=%0d want=4", cnt0);
        end
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        vectors++;
        if ({cnt0, empty0, ovf0, udf0, rv0} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL flush got=c%0d e%b o%b u%b v%b want=c0 e1 o0 u0 v0",
                     cnt0, empty0, ovf0, udf0, rv0);
        end
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        vectors++;
        if (cnt0 !== 4'd5) begin
            miscompares++;
            $display("FAIL burst got=%0d want=5", cnt0);
        end
        #1;
        mon_en = 1'b0;
        RST = 1'b0;
        #1;
        vectors++;
        if ({rd0, rv0, full0, empty0, af0, ae0, cnt0, ovf0, udf0} !==
            {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0} ||
            {rd1, rv1, cnt1} !== {8'h00, 1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL async_rst got=%02h v%b c%0d e%b ae%b fwft=%02h c%0d",
                     rd0, rv0, cnt0, empty0, ae0, rd1, cnt1);
        end
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        mon_en = 1'b1;
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_fwft();
        test_flush();
        test_async_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_reads got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
